dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one access at a time, waits LATENCY
// cycles, then pulses done. Stores commit at the end of the response
// cycle, loads are registered into r_data.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   req, we            access request, 1 = store / 0 = load
//   address, width     byte address, size (00 byte, 01 half, 10 word)
//   usignext, w_data   zero-extend loads, right-aligned store data
//   r_data             registered load result, held between loads
//   pause, done        stall to core, one-cycle completion pulse
//   misalign           illegal access rejected this cycle
module dmem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [1:0]  width,
    input  logic        usignext,
    input  logic [31:0] w_data,
    output logic [31:0] r_data,
    output logic        pause,
    output logic        done,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]    cnt;
    logic          we_q;
    logic [AW+1:0] addr_q;
    logic [1:0]    width_q;
    logic          usign_q;
    logic [31:0]   wdata_q;

    logic          legal;
    logic          accept;
    logic          load_fire;
    logic          store_fire;
    logic [AW-1:0] idx;
    logic [31:0]   word_rd;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_val;
    logic [3:0]    wmask;
    logic [31:0]   wword;

    logic [31:0]   mem [DEPTH_WORDS];

    // Address bits above the storage range are ignored (accesses wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[31:AW+2];

    always_comb begin
        case (width)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~address[0];
            2'b10:   legal = (address[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign accept = (state == S_IDLE) && req && legal;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs; reset forces everything quiet in the same cycle.
    always_comb begin
        pause    = 1'b0;
        done     = 1'b0;
        misalign = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    pause    = req && legal;
                    misalign = req && !legal;
                end
                S_WAIT: begin
                    pause = 1'b1;
                end
                S_RESP: begin
                    done = 1'b1;
                end
                default: begin
                    pause = 1'b0;
                end
            endcase
        end
    end

    assign load_fire  = (state == S_WAIT) && (cnt == 4'd0) && !we_q;
    assign store_fire = (state == S_RESP) && we_q && !reset;

    // Request latch, wait counter and load result register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= 2'b00;
            usign_q <= 1'b0;
            wdata_q <= 32'h0;
            r_data  <= 32'h0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                we_q    <= we;
                addr_q  <= address[AW+1:0];
                width_q <= width;
                usign_q <= usignext;
                wdata_q <= w_data;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (load_fire) begin
                r_data <= load_val;
            end
        end
    end

    assign idx     = addr_q[AW+1:2];
    assign word_rd = mem[idx];

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_v = word_rd[7:0];
            2'd1:    byte_v = word_rd[15:8];
            2'd2:    byte_v = word_rd[23:16];
            default: byte_v = word_rd[31:24];
        endcase
        half_v = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    end

    always_comb begin
        case (width_q)
            2'b00: begin
                load_val = usign_q ? {24'h0, byte_v}
                                   : {{24{byte_v[7]}}, byte_v};
            end
            2'b01: begin
                load_val = usign_q ? {16'h0, half_v}
                                   : {{16{half_v[15]}}, half_v};
            end
            default: begin
                load_val = word_rd;
            end
        endcase
    end

    // Store data is replicated across lanes; the mask picks the lanes.
    always_comb begin
        case (width_q)
            2'b00: begin
                wword = {4{wdata_q[7:0]}};
                wmask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wword = {2{wdata_q[15:0]}};
                wmask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wword = wdata_q;
                wmask = 4'b1111;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2,
// DEPTH_WORDS=1024); one task per scenario.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] address;
    logic [1:0]  width;
    logic        usignext;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        pause;
    logic        done;
    logic        misalign;

    int vecs = 0;
    int errs = 0;

    int          dc;
    int          pc;
    logic [31:0] rd;
    logic        xd;

    dmem_responder #(
        .LATENCY(2),
        .DEPTH_WORDS(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .we(we),
        .address(address),
        .width(width),
        .usignext(usignext),
        .w_data(w_data),
        .r_data(r_data),
        .pause(pause),
        .done(done),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req      = 1'b0;
        we       = 1'b0;
        address  = 32'h0;
        width    = 2'b10;
        usignext = 1'b0;
        w_data   = 32'h0;
    endtask

    // One access; inputs are scrambled while it is in flight.
    task automatic access(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [1:0]  wd,
        input  logic        us,
        input  logic [31:0] d,
        output int          dcyc,
        output int          pcnt,
        output logic [31:0] rdat,
        output logic        xdone
    );
        @(negedge clk);
        req = 1'b1; we = w; address = a;
        width = wd; usignext = us; w_data = d;
        #1;
        pcnt = int'(pause);
        dcyc = -1;
        rdat = 32'hx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req      = 1'b1;
            we       = 1'($urandom);
            address  = $urandom;
            width    = 2'($urandom);
            usignext = 1'($urandom);
            w_data   = $urandom;
            #1;
            if (pause) pcnt++;
            if (done) begin
                dcyc = i;
                rdat = r_data;
                break;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        xdone = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 1'b1; we = 1'b0; address = 32'h0;
        width = 2'b10; usignext = 1'b0; w_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        vecs++; if (pause !== 1'b0) begin errs++;
            $display("FAIL rst_pause: got %b want 0", pause); end
        vecs++; if (done !== 1'b0) begin errs++;
            $display("FAIL rst_done: got %b want 0", done); end
        vecs++; if (r_data !== 32'h0) begin errs++;
            $display("FAIL rst_rdata: got %h want 0", r_data); end
        @(negedge clk);
        width = 2'b11;
        #1;
        vecs++; if (misalign !== 1'b0) begin errs++;
            $display("FAIL rst_misalign: got %b want 0", misalign); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        vecs++; if (pause !== 1'b0) begin errs++;
            $display("FAIL idle_pause: got %b want 0", pause); end
    endtask

    task automatic test_word();
        access(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, dc, pc, rd, xd);
        vecs++; if (dc !== 3) begin errs++;
            $display("FAIL st_done_cyc: got %0d want 3", dc); end
        vecs++; if (pc !== 3) begin errs++;
            $display("FAIL st_pause_cnt: got %0d want 3", pc); end
        vecs++; if (xd !== 1'b0) begin errs++;
            $display("FAIL st_done_len: got %b want 0", xd); end
        vecs++; if (r_data !== 32'h0) begin errs++;
            $display("FAIL st_rdata_hold: got %h want 0", r_data); end
        access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (dc !== 3) begin errs++;
            $display("FAIL ld_done_cyc: got %0d want 3", dc); end
        vecs++; if (pc !== 3) begin errs++;
            $display("FAIL ld_pause_cnt: got %0d want 3", pc); end
        vecs++; if (rd !== 32'hDEADBEEF) begin errs++;
            $display("FAIL ld_word: got %h want deadbeef", rd); end
        vecs++; if (r_data !== 32'hDEADBEEF) begin errs++;
            $display("FAIL ld_hold: got %h want deadbeef", r_data); end
    endtask

    task automatic test_byte_half();
        logic [31:0] exp [7];
        logic [31:0] adr [7];
        logic [1:0]  wdt [7];
        logic        usg [7];
        access(1'b1, 32'h13, 2'b00, 1'b0, 32'hABCDEF80, dc, pc, rd, xd);
        adr = '{32'h13, 32'h13, 32'h11, 32'h10,
                32'h12, 32'h10, 32'h10};
        wdt = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        usg = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFBE,
                32'h000000EF, 32'hFFFF80AD, 32'h0000BEEF,
                32'hFFFFBEEF};
        for (int i = 0; i < 7; i++) begin
            access(1'b0, adr[i], wdt[i], usg[i], 32'h0,
                   dc, pc, rd, xd);
            vecs++; if (rd !== exp[i]) begin errs++;
                $display("FAIL ld_sub%0d: got %h want %h",
                         i, rd, exp[i]); end
        end
        access(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h80ADBEEF) begin errs++;
            $display("FAIL byte_lane: got %h want 80adbeef", rd); end
    endtask

    task automatic test_half_store();
        access(1'b1, 32'h20, 2'b10, 1'b0, 32'hAABBCCDD, dc, pc, rd, xd);
        access(1'b1, 32'h22, 2'b01, 1'b0, 32'h55551234, dc, pc, rd, xd);
        vecs++; if (r_data !== 32'h80ADBEEF) begin errs++;
            $display("FAIL st_no_rdata: got %h want 80adbeef", r_data); end
        access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h1234CCDD) begin errs++;
            $display("FAIL half_st: got %h want 1234ccdd", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] adr [3];
        logic [1:0]  wdt [3];
        access(1'b1, 32'h04, 2'b10, 1'b0, 32'h01020304, dc, pc, rd, xd);
        adr = '{32'h06, 32'h20, 32'h21};
        wdt = '{2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 1'b1; we = 1'b1; address = adr[i];
            width = wdt[i]; w_data = 32'hFFFFFFFF;
            #1;
            vecs++; if (misalign !== 1'b1) begin errs++;
                $display("FAIL mis%0d_flag: got %b want 1", i, misalign); end
            vecs++; if (pause !== 1'b0) begin errs++;
                $display("FAIL mis%0d_pause: got %b want 0", i, pause); end
            @(negedge clk);
            idle_inputs();
            #1;
            vecs++; if (pause !== 1'b0 || done !== 1'b0) begin errs++;
                $display("FAIL mis%0d_idle: got pause=%b done=%b want 0 0",
                         i, pause, done); end
            vecs++; if (r_data !== 32'h1234CCDD) begin errs++;
                $display("FAIL mis%0d_rdata: got %h want 1234ccdd",
                         i, r_data); end
        end
        repeat (4) @(negedge clk);
        access(1'b0, 32'h04, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h01020304) begin errs++;
            $display("FAIL mis_mem04: got %h want 01020304", rd); end
        access(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h1234CCDD) begin errs++;
            $display("FAIL mis_mem20: got %h want 1234ccdd", rd); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        access(1'b1, 32'h40, 2'b10, 1'b0, 32'h11111111, dc, pc, rd, xd);
        @(negedge clk);
        req = 1'b1; we = 1'b1; address = 32'h40;
        width = 2'b10; w_data = 32'h99999999;
        #1;
        vecs++; if (pause !== 1'b1) begin errs++;
            $display("FAIL ab_accept: got %b want 1", pause); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        vecs++; if (pause !== 1'b0) begin errs++;
            $display("FAIL ab_rst_pause: got %b want 0", pause); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vecs++; if (pause !== 1'b0) begin errs++;
            $display("FAIL ab_next_pause: got %b want 0", pause); end
        vecs++; if (r_data !== 32'h0) begin errs++;
            $display("FAIL ab_rdata: got %h want 0", r_data); end
        seen = done;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        vecs++; if (seen !== 1'b0) begin errs++;
            $display("FAIL ab_no_done: got %b want 0", seen); end
        @(negedge clk);
        req = 1'b1; we = 1'b1; address = 32'h40;
        width = 2'b10; w_data = 32'h77777777;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vecs++; if (done !== 1'b0) begin errs++;
            $display("FAIL ab_resp_done: got %b want 0", done); end
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h11111111) begin errs++;
            $display("FAIL ab_mem40: got %h want 11111111", rd); end
    endtask

    task automatic test_wrap();
        access(1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFEF00D, dc, pc, rd, xd);
        access(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'hCAFEF00D) begin errs++;
            $display("FAIL wrap_0: got %h want cafef00d", rd); end
        access(1'b0, 32'hFFFFF002, 2'b01, 1'b1, 32'h0, dc, pc, rd, xd);
        vecs++; if (rd !== 32'h0000CAFE) begin errs++;
            $display("FAIL wrap_hi: got %h want 0000cafe", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_half_store();
        test_misalign();
        test_reset_abort();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
